// File: rtl/hazard_pkg.sv
// Shared types and widths for the pipeline hazard controller.
package hazard_pkg;
  localparam int STATE_W = 2;
  localparam int REG_W   = 5;
  localparam int STAT_W  = 16;

  typedef enum logic [STATE_W-1:0] {
    RUN     = 2'd0,
    MC_WAIT = 2'd1,
    FLUSH   = 2'd2
  } state_t;
endpackage

// File: rtl/mc_timer.sv
// Saturating up-counter for the multi-cycle wait; tc marks the forced-release count.
module mc_timer
  import hazard_pkg::*;
#(
  parameter int CNT_W  = 8,
  parameter int TC_VAL = 254
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic tc
);
  logic [CNT_W-1:0] count;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      count <= '0;
    else if (clr)
      count <= '0;
    else if (en && (count != {CNT_W{1'b1}}))
      count <= count + 1'b1;
  end

  assign tc = (count == CNT_W'(TC_VAL));
endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Hazard/sequencing controller for the IF/ID and ID/EX registers and the PC.
// Define HAZARD_STATS_EN to add the StallCount/FlushCount statistics ports.
//
// state   | meaning
// RUN     | normal issue; branch, multi-cycle, load-use and jump events handled here
// MC_WAIT | pipeline frozen while the multi-cycle unit works (timeout guarded)
// FLUSH   | extra flush cycles after a taken branch
module pipeline_hazard_ctrl
  import hazard_pkg::*;
#(
  parameter int FLUSH_CYCLES = 1,
  parameter int MC_TIMEOUT   = 255,
  parameter int CNT_W        = 8
) (
  input  logic             Clk,
  input  logic             Rst,
  input  logic             LoadEX,
  input  logic [REG_W-1:0] LoadRtEX,
  input  logic [REG_W-1:0] RsID,
  input  logic [REG_W-1:0] RtID,
  input  logic             RtUsedID,
  input  logic             JumpID,
  input  logic             BranchTakenEX,
  input  logic             McStart,
  input  logic             McDone,
  output logic             PCWrite,
  output logic             IFIDWrite,
  output logic             IFIDFlush,
  output logic             IDEXBubble,
  output logic             IDEXHold,
  output logic             McBusy,
  output logic             McTimeout,
`ifdef HAZARD_STATS_EN
  output logic [STAT_W-1:0] StallCount,
  output logic [STAT_W-1:0] FlushCount,
`endif
  output logic [STATE_W-1:0] StateOut
);
  localparam logic [3:0] FLUSH_INIT = 4'(FLUSH_CYCLES);

  state_t     state, next_state;
  logic [3:0] fcnt, next_fcnt;
  logic       mc_timeout, set_timeout;
  logic       tc, load_use, mc_release;
  logic       pc_write, ifid_write, ifid_flush, idex_bubble, idex_hold, mc_busy;

  assign load_use = LoadEX && (LoadRtEX != '0) &&
                    ((LoadRtEX == RsID) || (RtUsedID && (LoadRtEX == RtID)));
  assign mc_release  = McDone || tc;
  assign set_timeout = (state == MC_WAIT) && tc && !McDone;

  mc_timer #(.CNT_W(CNT_W), .TC_VAL(MC_TIMEOUT - 1)) u_mc_timer (
    .clk (Clk),
    .rst (Rst),
    .clr (state != MC_WAIT),
    .en  (state == MC_WAIT),
    .tc  (tc)
  );

  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      state      <= RUN;
      fcnt       <= '0;
      mc_timeout <= 1'b0;
    end else begin
      state <= next_state;
      fcnt  <= next_fcnt;
      if (set_timeout)
        mc_timeout <= 1'b1;
    end
  end

  always_comb begin
    next_state = state;
    next_fcnt  = fcnt;
    case (state)
      RUN: begin
        if (BranchTakenEX) begin
          if (FLUSH_CYCLES > 0) begin
            next_state = FLUSH;
            next_fcnt  = FLUSH_INIT;
          end
        end else if (McStart && !McDone) begin
          next_state = MC_WAIT;
        end
      end
      MC_WAIT: if (mc_release) next_state = RUN;
      FLUSH: begin
        if (BranchTakenEX) begin
          next_fcnt = FLUSH_INIT;
        end else begin
          next_fcnt = fcnt - 1'b1;
          if (fcnt <= 4'd1)
            next_state = RUN;
        end
      end
      default: next_state = RUN;
    endcase
  end

  always_comb begin
    pc_write    = 1'b1;
    ifid_write  = 1'b1;
    ifid_flush  = 1'b0;
    idex_bubble = 1'b0;
    idex_hold   = 1'b0;
    mc_busy     = 1'b0;
    case (state)
      RUN: begin
        if (BranchTakenEX) begin
          ifid_flush  = 1'b1;
          idex_bubble = 1'b1;
        end else if (McStart && !McDone) begin
          pc_write   = 1'b0;
          ifid_write = 1'b0;
          idex_hold  = 1'b1;
          mc_busy    = 1'b1;
        end else if (McStart) begin
          // op finished in its start cycle: nothing to stall
          pc_write = 1'b1;
        end else if (load_use) begin
          pc_write    = 1'b0;
          ifid_write  = 1'b0;
          idex_bubble = 1'b1;
        end else if (JumpID) begin
          ifid_flush = 1'b1;
        end
      end
      MC_WAIT: begin
        if (!mc_release) begin
          pc_write   = 1'b0;
          ifid_write = 1'b0;
          idex_hold  = 1'b1;
          mc_busy    = 1'b1;
        end
      end
      FLUSH: begin
        ifid_flush  = 1'b1;
        idex_bubble = 1'b1;
      end
      default: ;
    endcase
  end

  // reset overrides the Mealy outputs: freeze the PC and bubble ID/EX
  assign PCWrite    = !Rst && pc_write;
  assign IFIDWrite  = !Rst && ifid_write;
  assign IFIDFlush  = !Rst && ifid_flush;
  assign IDEXBubble = Rst || idex_bubble;
  assign IDEXHold   = !Rst && idex_hold;
  assign McBusy     = !Rst && mc_busy;
  assign McTimeout  = mc_timeout;
  assign StateOut   = state;

`ifdef HAZARD_STATS_EN
  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      StallCount <= '0;
      FlushCount <= '0;
    end else begin
      if (!PCWrite && (StallCount != {STAT_W{1'b1}}))
        StallCount <= StallCount + 1'b1;
      if (IFIDFlush && (FlushCount != {STAT_W{1'b1}}))
        FlushCount <= FlushCount + 1'b1;
    end
  end
`endif
endmodule

// File: doc/pipeline_hazard_ctrl.md
# pipeline_hazard_ctrl

Hazard and sequencing controller for the five-stage pipeline. It sits beside the IF/ID and ID/EX pipeline registers and decides each cycle whether they load, hold, bubble or flush, and whether the PC advances. It covers load-use stalls, taken-branch and jump flushes, and multi-cycle EX operations with a timeout guard. All outputs are Mealy: combinational from the registered state and the current-cycle inputs.

## Interface
- FLUSH_CYCLES, 1, extra cycles of IF/ID and ID/EX flush after a taken branch (0..15)
- MC_TIMEOUT, 255, maximum cycles spent in MC_WAIT before a forced release (1..2^CNT_W-1)
- CNT_W, 8, width of the multi-cycle timer
- Clk  in  1  clock, rising edge
- Rst  in  1  reset, asynchronous, active-high
- LoadEX  in  1  instruction in EX is a load (ID/EX MemR nonzero)
- LoadRtEX  in  5  destination register of the load in EX
- RsID, RtID  in  5 each  source registers of the instruction in ID
- RtUsedID  in  1  instruction in ID reads Rt
- JumpID  in  1  J or JAL decoded in ID
- BranchTakenEX  in  1  branch resolved taken in EX
- McStart  in  1  multi-cycle operation in EX requests start
- McDone  in  1  multi-cycle unit has finished
- PCWrite  out  1  PC loads its next value
- IFIDWrite  out  1  IF/ID loads
- IFIDFlush  out  1  IF/ID loads a NOP
- IDEXBubble  out  1  ID/EX loads zeros in all control fields
- IDEXHold  out  1  ID/EX keeps its contents
- McBusy  out  1  multi-cycle operation outstanding
- McTimeout  out  1  sticky flag; a multi-cycle timeout occurred
- StateOut  out  2  current state (RUN=0, MC_WAIT=1, FLUSH=2)

## Operation
- Default outputs in RUN with no event: PCWrite=1, IFIDWrite=1, all other outputs 0.
- RUN handles events in priority order:
  1. BranchTakenEX: IFIDFlush=1, IDEXBubble=1, PCWrite=1. If FLUSH_CYCLES>0, go to FLUSH with flush counter = FLUSH_CYCLES.
  2. McStart && !McDone: PCWrite=0, IFIDWrite=0, IDEXHold=1, McBusy=1. Go to MC_WAIT with timer = 0.
  3. McStart && McDone: no stall.
  4. Load-use hazard, defined as LoadEX && LoadRtEX!=0 && (LoadRtEX==RsID || (RtUsedID && LoadRtEX==RtID)): PCWrite=0, IFIDWrite=0, IDEXBubble=1. Stay in RUN; the hazard clears on its own next cycle.
  5. JumpID: IFIDFlush=1, PCWrite=1.
- MC_WAIT:
  - While waiting: PCWrite=0, IFIDWrite=0, IDEXHold=1, McBusy=1. Timer increments each cycle. BranchTakenEX and JumpID are ignored.
  - McDone, or timer==MC_TIMEOUT-1: this cycle behaves like RUN default (PCWrite=1, IFIDWrite=1, IDEXHold=0, McBusy=0); next state RUN.
  - Timeout release without McDone: set McTimeout. It stays set until Rst.
- FLUSH:
  - Each cycle: IFIDFlush=1, IDEXBubble=1, PCWrite=1. Counter decrements.
  - Counter==1: next state RUN.
  - A new BranchTakenEX reloads the counter with FLUSH_CYCLES.
- The timer saturates and never wraps. The flush counter is 4 bits.

## Timing
- Latency is zero: outputs respond in the same cycle as the inputs. State updates on the rising edge of Clk.
- During Rst: PCWrite=0, IFIDWrite=0, IDEXBubble=1, IFIDFlush=0, IDEXHold=0, McBusy=0, McTimeout=0, StateOut=RUN. Timer and flush counter = 0.
- Reset asserted mid-MC_WAIT or mid-FLUSH: return to RUN immediately. No pending operation is remembered.
- Load-use stall is exactly 1 cycle.
- A multi-cycle op completing N cycles after start holds the pipeline for N cycles (release in cycle N).
- Taken branch flushes for 1+FLUSH_CYCLES cycles.

## Configuration
- HAZARD_STATS_EN defined: adds output ports StallCount[15:0] and FlushCount[15:0].
  - StallCount counts cycles with PCWrite=0 while Rst is low.
  - FlushCount counts cycles with IFIDFlush=1.
  - Both saturate at 16'hFFFF and clear on Rst.
- HAZARD_STATS_EN not defined: the ports and counters do not exist; all other behaviour is identical.

## Structure
- Package hazard_pkg holds:
  - the state enum (RUN, MC_WAIT, FLUSH) and its 2-bit width;
  - the register-index width (5);
  - the statistics counter width (16).
- One sub-module, mc_timer: a CNT_W-bit saturating counter with clear, enable and a terminal-count output. It is instantiated once.

## Test plan
- Rst high for 3 cycles, then low → during reset PCWrite=0, IDEXBubble=1; after release StateOut=0, PCWrite=1.
- LoadEX=1, LoadRtEX=5, RsID=5 → one cycle with PCWrite=0 and IDEXBubble=1. Repeat with LoadRtEX=0 → no stall.
- McStart=1, McDone asserted 4 cycles later → StateOut=1 for 4 cycles with IDEXHold=1; release in the McDone cycle; McTimeout=0.
- MC_TIMEOUT=8, McDone never asserted → forced release after 8 cycles; McTimeout=1 and it persists.
- FLUSH_CYCLES=2, BranchTakenEX pulse → IFIDFlush=1 for 3 consecutive cycles, then RUN.
- BranchTakenEX and a load-use hazard in the same cycle → flush wins: PCWrite=1 and IFIDFlush=1. With HAZARD_STATS_EN, FlushCount increments and StallCount does not.
